// File: rtl/riscv_multicycle_control_pkg.sv
// Shared types for the multicycle RV32I controller.
// Contents:
//   alu_control_t  - ALU operation code driven to the datapath ALU
//   state_t        - controller FSM states (16 states, 4-bit encoding)
//   OP_*           - RV32I major opcodes recognised by the decoder
//   alu_src_a_t / alu_src_b_t / result_src_t / imm_src_t - datapath select encodings
//   imm_src_for()   - immediate format for an opcode
//   branch_alu()    - ALU operation used to evaluate a branch condition
//   branch_taken()  - branch resolution from funct3 and the ALU flags
package riscv_multicycle_control_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_control_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALRLINK = 4'd12,
    S_LUI      = 4'd13,
    S_AUIPC    = 4'd14,
    S_ERROR    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    SRCA_PC    = 2'b00,
    SRCA_OLDPC = 2'b01,
    SRCA_RS1   = 2'b10,
    SRCA_ZERO  = 2'b11
  } alu_src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_IMM  = 2'b01,
    SRCB_FOUR = 2'b10
  } alu_src_b_t;

  typedef enum logic [1:0] {
    RES_ALUOUT    = 2'b00,
    RES_MEMDATA   = 2'b01,
    RES_ALURESULT = 2'b10
  } result_src_t;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  // Unknown opcodes fall back to the I format; they never reach a state
  // that consumes the immediate.
  function automatic imm_src_t imm_src_for(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

  function automatic alu_control_t branch_alu(input logic [2:0] funct3);
    case (funct3[2:1])
      2'b00:   return ALU_SUB;   // beq / bne compare via subtraction
      2'b10:   return ALU_SLT;   // blt / bge
      2'b11:   return ALU_SLTU;  // bltu / bgeu
      default: return ALU_ADD;
    endcase
  endfunction

  // For SLT/SLTU the ALU result is 1 when a < b, so "less than" is !zero.
  function automatic logic branch_taken(input logic [2:0] funct3,
                                        input logic zero,
                                        input logic equal);
    case (funct3)
      3'b000:          return equal;
      3'b001:          return !equal;
      3'b100, 3'b110:  return !zero;
      3'b101, 3'b111:  return zero;
      default:         return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_multicycle_control_alu_decoder.sv
// Combinational ALU operation decoder for R-type and I-type arithmetic.
// Ports:
//   funct3_i      in  3  instr[14:12]
//   funct7b5_i    in  1  instr[30]
//   is_rtype_i    in  1  1 when decoding a register-register instruction
//   alu_control_o out    ALU operation
module riscv_multicycle_control_alu_decoder
  import riscv_multicycle_control_pkg::*;
(
  input  logic [2:0]   funct3_i,
  input  logic         funct7b5_i,
  input  logic         is_rtype_i,
  output alu_control_t alu_control_o
);

  always_comb begin
    alu_control_o = ALU_ADD;
    case (funct3_i)
      // instr[30] is part of the immediate for ADDI, so SUB exists only in R-type.
      3'b000:  alu_control_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_control_o = ALU_SLL;
      3'b010:  alu_control_o = ALU_SLT;
      3'b011:  alu_control_o = ALU_SLTU;
      3'b100:  alu_control_o = ALU_XOR;
      // Shift-right type is selected by instr[30] for both SRAI and SRA.
      3'b101:  alu_control_o = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110:  alu_control_o = ALU_OR;
      3'b111:  alu_control_o = ALU_AND;
      default: alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/riscv_multicycle_control.sv
// Multicycle RV32I main controller. Sequences each instruction from FETCH
// through writeback and drives the ALU operation plus datapath selects and
// write strobes. Branches are resolved from the ALU zero/equal flags.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   op, funct3, funct7b5  instruction fields from the instruction register
//   zero, equal       ALU flags (result == 0, a == b)
//   mem_ready         memory completes the current access this cycle
//   alu_control       ALU operation
//   alu_src_a         00 PC, 01 OLDPC, 10 rs1, 11 zero
//   alu_src_b         00 rs2, 01 imm, 10 const 4
//   result_src        00 ALUOut reg, 01 mem data, 10 ALU result
//   imm_src           000 I, 001 S, 010 B, 011 J, 100 U
//   adr_src           0 PC, 1 result bus
//   ir_write, pc_write, reg_write, mem_write  write strobes
//   illegal           high while parked in ERROR
//   state_dbg         current FSM state (state_t encoding) for observation
//
// Memory handshake: the controller holds the address select and strobes of
// a memory state steady for as long as it stays in that state; the access
// completes in the cycle mem_ready is high, and only then does the FSM move
// on. Strobes that commit a fetch (ir_write/pc_write) are qualified by
// mem_ready so nothing changes while waiting, whereas mem_write stays high
// up to and including the completing cycle.
module riscv_multicycle_control
  import riscv_multicycle_control_pkg::*;
#(
  parameter bit ERROR_ON_ILLEGAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [6:0]   op,
  input  logic [2:0]   funct3,
  input  logic         funct7b5,
  input  logic         zero,
  input  logic         equal,
  input  logic         mem_ready,
  output alu_control_t alu_control,
  output logic [1:0]   alu_src_a,
  output logic [1:0]   alu_src_b,
  output logic [1:0]   result_src,
  output logic [2:0]   imm_src,
  output logic         adr_src,
  output logic         ir_write,
  output logic         pc_write,
  output logic         reg_write,
  output logic         mem_write,
  output logic         illegal,
  output logic [3:0]   state_dbg
);

  // Where an unrecognised encoding sends the FSM.
  localparam state_t ILLEGAL_NEXT = ERROR_ON_ILLEGAL ? S_ERROR : S_FETCH;

  state_t       state_q, state_d;
  alu_control_t dec_alu;
  alu_src_a_t   src_a;
  alu_src_b_t   src_b;
  result_src_t  res_src;
  imm_src_t     imm_sel;

  riscv_multicycle_control_alu_decoder u_alu_decoder (
    .funct3_i      (funct3),
    .funct7b5_i    (funct7b5),
    .is_rtype_i    (state_q == S_EXECR),
    .alu_control_o (dec_alu)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          // Only word loads/stores are supported.
          OP_LOAD, OP_STORE: state_d = (funct3 == 3'b010) ? S_MEMADR : ILLEGAL_NEXT;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = (funct3[2:1] == 2'b01) ? ILLEGAL_NEXT : S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default:           state_d = ILLEGAL_NEXT;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_JALR:     state_d = S_JALRLINK;
      S_JALRLINK: state_d = S_ALUWB;
      S_LUI:      state_d = S_ALUWB;
      S_AUIPC:    state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output logic.
  always_comb begin
    alu_control = ALU_ADD;
    src_a       = SRCA_PC;
    src_b       = SRCB_RS2;
    res_src     = RES_ALUOUT;
    imm_sel     = imm_src_for(op);
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    mem_write   = 1'b0;
    illegal     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imm_sel  = IMM_I;  // IR not yet loaded, immediate meaningless
        src_a    = SRCA_PC;
        src_b    = SRCB_FOUR;
        res_src  = RES_ALURESULT;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        // Speculatively form OLDPC+imm; branch and JAL consume it from ALUOut.
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        src_a = SRCA_RS1;
        src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        res_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        res_src   = RES_MEMDATA;
        reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        res_src   = RES_ALUOUT;
        mem_write = 1'b1;
      end
      S_EXECR: begin
        src_a       = SRCA_RS1;
        src_b       = SRCB_RS2;
        alu_control = dec_alu;
      end
      S_EXECI: begin
        src_a       = SRCA_RS1;
        src_b       = SRCB_IMM;
        alu_control = dec_alu;
      end
      S_ALUWB: begin
        res_src   = RES_ALUOUT;
        reg_write = 1'b1;
      end
      S_BRANCH: begin
        src_a       = SRCA_RS1;
        src_b       = SRCB_RS2;
        res_src     = RES_ALUOUT;
        alu_control = branch_alu(funct3);
        pc_write    = branch_taken(funct3, zero, equal);
      end
      S_JAL: begin
        // PC <- target held in ALUOut; ALU meanwhile forms the link value.
        src_a    = SRCA_OLDPC;
        src_b    = SRCB_FOUR;
        res_src  = RES_ALUOUT;
        pc_write = 1'b1;
      end
      S_JALR: begin
        // Target comes straight off the ALU result (rs1+imm).
        src_a    = SRCA_RS1;
        src_b    = SRCB_IMM;
        res_src  = RES_ALURESULT;
        pc_write = 1'b1;
      end
      S_JALRLINK: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_FOUR;
      end
      S_LUI: begin
        src_a = SRCA_ZERO;
        src_b = SRCB_IMM;
      end
      S_AUIPC: begin
        src_a = SRCA_OLDPC;
        src_b = SRCB_IMM;
      end
      S_ERROR: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
    // A reset cycle abandons the in-flight state: nothing may commit.
    if (rst) begin
      ir_write  = 1'b0;
      pc_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign alu_src_a  = src_a;
  assign alu_src_b  = src_b;
  assign result_src = res_src;
  assign imm_src    = imm_sel;
  assign state_dbg  = state_q;

endmodule
